// File: rtl/queue_serializer.sv
// Pops bytes from the queue and shifts them out MSB-first with a per-bit valid/ready handshake.
// Latency: pop to first valid bit is 2 cycles; ready_in low in SHIFT holds all state for that cycle.
module queue_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk_10khz,
  input  logic                  queue_rst,
  input  logic                  enable_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [DATA_WIDTH-1:0] queue_data_in,
  input  logic                  ready_in,
  output logic                  dequeue_out,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [7:0]            byte_count_out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;

  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    dequeue_out    = 1'b0;
    data_out       = 1'b0;
    write_out      = 1'b0;
    frame_done_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_in && (len_in != '0)) state_d = POP;
      end
      POP: begin
        dequeue_out = 1'b1;
        state_d     = LOAD;
      end
      // The queue updates its output byte on the pop edge, so it is sampled here.
      LOAD: begin
        shift_d   = queue_data_in;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        write_out = 1'b1;
        data_out  = shift_q[DATA_WIDTH-1];
        if (ready_in) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = DONE;
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        frame_done_out = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_out       = (state_q != IDLE);
  assign byte_count_out = byte_cnt_q;

endmodule

// File: tb/tb_queue_serializer.sv
// Directed bench for queue_serializer with a small queue model feeding len_in/queue_data_in.
module tb_queue_serializer;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk_10khz = 1'b0;
  logic          queue_rst;
  logic          enable_in;
  logic [LW-1:0] len_in;
  logic [DW-1:0] queue_data_in;
  logic          ready_in;
  logic          dequeue_out;
  logic          data_out;
  logic          write_out;
  logic          busy_out;
  logic          frame_done_out;
  logic [7:0]    byte_count_out;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_cnt;
  logic [7:0] qmem[$];

  queue_serializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_10khz      (clk_10khz),
    .queue_rst      (queue_rst),
    .enable_in      (enable_in),
    .len_in         (len_in),
    .queue_data_in  (queue_data_in),
    .ready_in       (ready_in),
    .dequeue_out    (dequeue_out),
    .data_out       (data_out),
    .write_out      (write_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .byte_count_out (byte_count_out)
  );

  always #50 clk_10khz = ~clk_10khz;

  function automatic logic [LW-1:0] qlen();
    return (qmem.size() > 15) ? LW'(15) : LW'(qmem.size());
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic deq, input logic dat,
                          input logic wr, input logic busy, input logic done);
    chk({tag, ".dequeue"}, {7'd0, dequeue_out}, {7'd0, deq});
    chk({tag, ".data"}, {7'd0, data_out}, {7'd0, dat});
    chk({tag, ".write"}, {7'd0, write_out}, {7'd0, wr});
    chk({tag, ".busy"}, {7'd0, busy_out}, {7'd0, busy});
    chk({tag, ".done"}, {7'd0, frame_done_out}, {7'd0, done});
    chk({tag, ".count"}, byte_count_out, exp_cnt);
  endtask

  // Queue model: a pop seen before the edge updates data and occupancy just after it.
  task automatic tick();
    logic deq;
    deq = dequeue_out;
    @(posedge clk_10khz);
    #1;
    if (deq && qmem.size() > 0) queue_data_in = qmem.pop_front();
    len_in = qlen();
    @(negedge clk_10khz);
  endtask

  // Starts at an IDLE cycle with the start condition set, ends at the IDLE cycle after DONE.
  task automatic run_frame(input logic [7:0] b, input int stall_bit, input int stall_n,
                           input int drop_bit);
    chk_outs("idle_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("pop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_outs("load", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = DW - 1; i >= 0; i--) begin
      tick(); chk_outs($sformatf("shift_bit%0d", i), 1'b0, b[i], 1'b1, 1'b1, 1'b0);
      if (i == drop_bit) enable_in = 1'b0;
      if (i == stall_bit) begin
        ready_in = 1'b0;
        repeat (stall_n) begin
          tick(); chk_outs($sformatf("stall_bit%0d", i), 1'b0, b[i], 1'b1, 1'b1, 1'b0);
        end
        ready_in = 1'b1;
      end
    end
    exp_cnt = exp_cnt + 8'd1;
    tick(); chk_outs("done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  initial begin
    logic [7:0] b;
    queue_rst     = 1'b1;
    enable_in     = 1'b1;
    ready_in      = 1'b1;
    len_in        = '0;
    queue_data_in = '0;
    exp_cnt       = 8'd0;

    // Reset, then idle with an empty queue
    repeat (2) @(negedge clk_10khz);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    queue_rst = 1'b0;
    repeat (20) begin
      tick(); chk_outs("idle_empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Single byte
    qmem.push_back(8'hA5); len_in = qlen();
    run_frame(8'hA5, -1, 0, -1);
    chk_outs("after_single", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: three stalled edges on bit 4
    qmem.push_back(8'h3C); len_in = qlen();
    run_frame(8'h3C, 4, 3, -1);

    // Back-to-back bytes, then no fourth pop
    qmem.push_back(8'h01); qmem.push_back(8'h80); qmem.push_back(8'hFF); len_in = qlen();
    run_frame(8'h01, -1, 0, -1);
    run_frame(8'h80, -1, 0, -1);
    run_frame(8'hFF, -1, 0, -1);
    chk("b2b_count", byte_count_out, 8'd5);
    repeat (15) begin
      chk_outs("b2b_drained", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end

    // Asynchronous reset while bit 5 is on the line
    qmem.push_back(8'hE7); len_in = qlen();
    chk_outs("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk_outs("rst_bit5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #10 queue_rst = 1'b1;
    #1;
    exp_cnt = 8'd0;
    chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_10khz);
    queue_rst = 1'b0;
    chk_outs("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    qmem.push_back(8'h3A); len_in = qlen();
    run_frame(8'h3A, -1, 0, -1);

    // Enable dropped mid-frame: frame completes, second byte stays queued
    qmem.push_back(8'h55); qmem.push_back(8'h66); len_in = qlen();
    run_frame(8'h55, -1, 0, 3);
    repeat (15) begin
      chk_outs("en_off_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end
    enable_in = 1'b1;
    run_frame(8'h66, -1, 0, -1);
    chk("en_count", byte_count_out, 8'd3);

    // 256 frames from a clean reset wrap the count back to zero
    queue_rst = 1'b1;
    repeat (2) @(negedge clk_10khz);
    queue_rst = 1'b0;
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      qmem.push_back(b); len_in = qlen();
      run_frame(b, -1, 0, -1);
    end
    chk("wrap_count", byte_count_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/queue_serializer.md
# queue_serializer

Drain-side serializer for the 10 kHz queue domain. When enabled and the queue reports a non-zero length, it pops one byte, shifts it out MSB-first as a serial bit stream with a per-bit valid/ready handshake, then returns for the next byte. It is the transmit counterpart of the deserializer: it turns queued parallel bytes back into serial bits. It connects directly to the queue's `len_out`, `data_out` and `dequeue_in`.

## Interface
- `DATA_WIDTH`, default 8: byte width and number of bits per frame.
- `LEN_WIDTH`, default 4: width of the queue occupancy input.
- `clk_10khz`  input  1: block clock. All state changes on the rising edge.
- `queue_rst`  input  1: asynchronous, active-high reset.
- `enable_in`  input  1: permits starting a new frame. Sampled only in IDLE.
- `len_in`  input  LEN_WIDTH: queue occupancy. Any non-zero value means data is available.
- `queue_data_in`  input  DATA_WIDTH: the queue's output byte.
- `ready_in`  input  1: the downstream sink accepts the current bit on this edge.
- `dequeue_out`  output  1: one-cycle pop request to the queue.
- `data_out`  output  1: serial bit, MSB first.
- `write_out`  output  1: `data_out` is valid.
- `busy_out`  output  1: high in every state except IDLE.
- `frame_done_out`  output  1: one-cycle pulse after the last bit is accepted.
- `byte_count_out`  output  8: running count of completed frames. Wraps modulo 256.

## Operation
- The FSM has five states: IDLE, POP, LOAD, SHIFT, DONE. All outputs are Moore outputs decoded from state and registers.
- **IDLE:** if `enable_in` is 1 and `len_in` is not 0, go to POP. Otherwise stay in IDLE.
- **POP:** `dequeue_out` is 1. Go to LOAD unconditionally.
  - The queue samples the pop request on this edge.
  - The queue's `len_in` and `queue_data_in` update on the same edge.
- **LOAD:** on the leaving edge, `shift_reg <= queue_data_in` and `bit_cnt <= 0`. Go to SHIFT.
- **SHIFT:** `write_out` is 1 and `data_out` is `shift_reg[DATA_WIDTH-1]`.
  - On an edge with `ready_in` = 1: shift left by one and increment `bit_cnt`.
  - If `bit_cnt` = DATA_WIDTH-1 on that accepting edge, go to DONE and increment `byte_count_out` on the same edge.
  - On an edge with `ready_in` = 0: hold all state. `data_out` and `write_out` stay stable.
- **DONE:** `frame_done_out` is 1. Go to IDLE.
- **Outputs outside SHIFT:** `data_out` = 0 and `write_out` = 0.
- **Enable gating:** `enable_in` gates frame starts only. Deasserting it mid-frame does not abort the frame; the frame completes and no further pop is issued.
- **Occupancy width:** `len_in` is not range-checked. Any non-zero pattern starts a frame.
- **Empty queue:** the block never pops while `len_in` = 0. No dequeue pulse is produced in that case.
- **Count width:** `bit_cnt` is wide enough to hold DATA_WIDTH-1. `byte_count_out` rolls over from 255 to 0.

## Timing
- **Reset values:** `dequeue_out`, `data_out`, `write_out`, `busy_out` and `frame_done_out` are all 0; `byte_count_out` = 0x00; state is IDLE; `shift_reg` and `bit_cnt` are 0.
- **Reset mid-frame:** `queue_rst` acts immediately, without waiting for a clock edge. The partial byte is discarded and is not counted. After release the block starts in IDLE.
- **Frame timeline with `ready_in` held at 1** (edge k is the edge that leaves the state active in cycle k):
  - cycle 0: IDLE, start condition true;
  - cycle 1: POP;
  - cycle 2: LOAD;
  - cycles 3–10: SHIFT, bits 7 down to 0;
  - cycle 11: DONE.
- Back-to-back frames: the next POP is at cycle 13 (cycle 12 is IDLE). Period is 12 cycles per byte.
- **Pop-to-first-bit latency:** 2 cycles from `dequeue_out` to the first valid bit.
- **Stalls:** each cycle of `ready_in` = 0 during SHIFT adds exactly one cycle to the frame.
- **`len_in` after a pop:** a decrement caused by this block's pop is visible from LOAD onward. IDLE therefore always sees the updated occupancy.

## Test plan
- **Idle after reset:** assert then release `queue_rst`, hold `len_in` = 0 and `enable_in` = 1 for 20 cycles.
  - Required: all outputs 0; no `dequeue_out` pulse.
- **Single byte:** `len_in` = 1, queue presents 0xA5 after the pop, `ready_in` = 1.
  - Required: `dequeue_out` high in cycle 1 only.
  - Required: `data_out` = 1,0,1,0,0,1,0,1 in cycles 3–10 with `write_out` = 1.
  - Required: `frame_done_out` high in cycle 11; `byte_count_out` = 1.
- **Backpressure:** byte 0x3C, `ready_in` = 0 for 3 cycles while bit 4 is presented.
  - Required: `data_out` holds 1 during the stall; the frame ends in cycle 14; the bit sequence is unchanged.
- **Back-to-back bytes:** `len_in` = 3, decrementing after each pop; bytes 0x01, 0x80, 0xFF.
  - Required: three pops, 12 cycles apart; three correct frames; `byte_count_out` = 3; no fourth pop.
- **Reset mid-frame:** assert `queue_rst` while bit 5 is on the line.
  - Required: outputs go to 0 with no clock edge; `byte_count_out` = 0; after release, a fresh frame shifts out correctly.
- **Enable drop and wrap:**
  - Deassert `enable_in` mid-frame. Required: the frame completes and no further pop occurs.
  - Run 256 frames. Required: `byte_count_out` returns to 0x00.
